srrc_tx_filter: RTL and testbench
=================================

# srrc_tx_filter

Symmetric square-root-raised-cosine pulse-shaping FIR for the transmit path, fed directly by the 4x zero-stuffing upsampler. It takes one 18-bit 1s17 sample per `sam_clk_en` tick, convolves it with a fixed 17-tap SRRC response (4 samples/symbol, 4-symbol span, beta 0.25), and drives the DAC/channel-model path with a pipelined, saturated 18-bit result.

## Interface
- `NUM_TAPS`, 17, tap count; odd; centre tap index (NUM_TAPS-1)/2
- `DATA_W`, 18, input/output sample width, 1s17
- `COEF_W`, 18, coefficient width, 1s17
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset; one clock domain only
- `sam_clk_en`  in  1  sample-rate enable, one-cycle pulse; every register in the block advances only on it
- `data_in`  in  DATA_W signed  zero-stuffed upsampler output, sampled on `sam_clk_en`
- `data_out`  out  DATA_W signed  filtered sample, registered, held between enables
- `data_valid`  out  1  high once the delay line and pipeline hold only post-reset samples

## Operation
- Delay line x[0..NUM_TAPS-1]: on enable, x[0] <= data_in and x[k] <= x[k-1].
- Stage P (pre-add): p[k] = x[k] + x[NUM_TAPS-1-k] for k < centre, 19-bit signed; centre term passes through, sign-extended.
- Stage M (multiply): m[k] = p[k] * h[k], 37-bit signed, 34 fractional bits.
- Stage S (sum): adder over centre+1 products into a 41-bit accumulator (4 guard bits); no intermediate truncation.
- Stage O (output): take acc[34:17]. If acc[40:34] are not all equal, saturate to 18'h1FFFF (positive) or 18'h20000 (negative). No wrap-around under any input.
- Fill counter: saturating counter, increments on each enable, stops at NUM_TAPS+3. `data_valid` = (count == NUM_TAPS+3).
- Coefficients are constants. No runtime coefficient load.

## Timing
- Reset (async assert): delay line, P/M/S/O registers and fill counter are cleared at once. `data_out` = 0, `data_valid` = 0. The block leaves reset on the first `clk` edge after `reset_n` rises.
- Latency: a sample captured on enable tick n first contributes to `data_out` at tick n+4, through stages P, M, S and O. The impulse response occupies ticks n+4 .. n+4+NUM_TAPS-1.
- `data_valid` rises on the 20th enable after reset, which is NUM_TAPS+3 = 20 enables.
- With `sam_clk_en` low, all state and outputs hold exactly, for any gap length. Back-to-back enables (every clk) are legal.
- Reset mid-stream discards all history. Post-reset output is identical to a cold start.

## Configuration
- `SRRC_ROUND_EN` defined: add 2^16 to the accumulator before the bit select. This is round-half-up. Saturation applies after rounding.
- Undefined: plain truncation, which rounds toward negative infinity. Latency is identical either way.

## Structure
- Shared package `mod_tx_pkg` holds `NUM_TAPS` default, the 1s17 width constants, the SRRC coefficient table h[0..centre] as signed constants, and the accumulator/guard-bit widths. Upsampler and bench read the same table.
- Sub-module `srrc_preadd_mult` covers one symmetric pair: it pre-adds, registers, multiplies and registers. It is instantiated once per pair, plus once for the centre tap with the mirror input tied to 0.

## Test plan
- Impulse: data_in = 18'h10000 (0.5) on one enable, zeros elsewhere. Required: data_out on ticks 4..20 equals h[k]>>>1 for k = 0..16, exactly symmetric, then returns to 0.
- DC: data_in = 18'h10000 held. Required: after `data_valid` rises, data_out is constant at (0.5*sum(h)) per the rounding mode.
- Saturation: data_in = 18'h1FFFF held gives 18'h1FFFF with no wrap. Alternating ±full-scale in an SRRC-matched pattern gives 18'h20000 on negative peaks.
- Enable gaps: random 1–7 cycle gaps between enables. Required: output sequence matches the gap-free run sample-for-sample, and it holds between enables.
- Reset mid-stream: assert `reset_n` = 0 for 1 cycle at tick 10 of an impulse run. Required: data_out = 0 and data_valid = 0 immediately, then a fresh impulse reproduces the cold-start response.
- Rounding: a single sample chosen so that acc[16:0] = 17'h10000. Required: output LSB is 1 higher with `SRRC_ROUND_EN` defined than without it.

Source files
------------

// File: rtl/mod_tx_pkg.sv
// Shared transmit-path constants: 1s17 sample/coefficient formats, accumulator sizing and the
// 17-tap SRRC half-table (4 samples/symbol, 4-symbol span, beta 0.25, DC gain ~1.52).
package mod_tx_pkg;

    localparam int NUM_TAPS = 17;
    localparam int CENTRE   = (NUM_TAPS - 1) / 2;
    localparam int DATA_W   = 18;
    localparam int COEF_W   = 18;
    localparam int FRAC_W   = 17;
    localparam int PRE_W    = DATA_W + 1;
    localparam int PROD_W   = PRE_W + COEF_W;
    localparam int GUARD_W  = 4;
    localparam int ACC_W    = PROD_W + GUARD_W;
    localparam int FILL_MAX = NUM_TAPS + 3;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    // h[k] for k = 0..CENTRE; h[NUM_TAPS-1-k] mirrors h[k].
    function automatic coef_t srrc_coef(input int k);
        coef_t h;
        case (k)
            0:       h = 18'sd2781;
            1:       h = -18'sd2883;
            2:       h = -18'sd8929;
            3:       h = -18'sd10419;
            4:       h = -18'sd3368;
            5:       h = 18'sd12471;
            6:       h = 18'sd32600;
            7:       h = 18'sd49449;
            8:       h = 18'sd56010;
            default: h = '0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/srrc_preadd_mult.sv
// One symmetric tap pair of the SRRC filter: registered pre-add followed by a registered
// constant multiply. The centre tap uses it with tap_b tied to zero.
module srrc_preadd_mult
    import mod_tx_pkg::*;
#(
    parameter logic signed [COEF_W-1:0] COEF = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sam_clk_en,
    input  logic signed [DATA_W-1:0] tap_a,
    input  logic signed [DATA_W-1:0] tap_b,
    output logic signed [PROD_W-1:0] prod
);

    logic signed [PRE_W-1:0]  pre_d;
    logic signed [PRE_W-1:0]  pre_q;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;

    always_comb begin
        pre_d  = pre_q;
        prod_d = prod_q;
        if (sam_clk_en) begin
            pre_d  = PRE_W'(tap_a) + PRE_W'(tap_b);
            prod_d = PROD_W'(pre_q) * PROD_W'(COEF);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            prod_q <= '0;
        end else begin
            pre_q  <= pre_d;
            prod_q <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/srrc_tx_filter.sv
// 17-tap symmetric SRRC transmit FIR with pre-add/multiply/sum/output pipeline and saturation.
// Define SRRC_ROUND_EN for round-half-up on the output; otherwise the output truncates.
module srrc_tx_filter #(
    parameter int NUM_TAPS = mod_tx_pkg::NUM_TAPS,
    parameter int DATA_W   = mod_tx_pkg::DATA_W,
    parameter int COEF_W   = mod_tx_pkg::COEF_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sam_clk_en,
    input  logic signed [DATA_W-1:0] data_in,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     data_valid
);

    import mod_tx_pkg::*;

    localparam int TAP_CENTRE = (NUM_TAPS - 1) / 2;
    localparam int FILL_DONE  = NUM_TAPS + 3;
    localparam int CNT_W      = $clog2(FILL_DONE + 1);
    localparam int OUT_MSB    = FRAC_W + DATA_W - 1;

`ifdef SRRC_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_ADD = ACC_W'(1 << (FRAC_W - 1));
`else
    localparam logic signed [ACC_W-1:0] ROUND_ADD = '0;
`endif

    logic signed [DATA_W-1:0] x_q [NUM_TAPS];
    logic signed [DATA_W-1:0] x_d [NUM_TAPS];
    logic signed [PROD_W-1:0] prod [TAP_CENTRE+1];
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [DATA_W-1:0] sat_val;
    logic signed [DATA_W-1:0] out_d;
    logic signed [DATA_W-1:0] out_q;
    logic [CNT_W-1:0]         cnt_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     ovf;
    logic                     unused_frac;

    always_comb begin
        x_d = x_q;
        if (sam_clk_en) begin
            x_d[0] = data_in;
            for (int k = 1; k < NUM_TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    for (genvar k = 0; k <= TAP_CENTRE; k++) begin : g_tap
        logic signed [DATA_W-1:0] mirror;
        if (k < TAP_CENTRE) begin : g_pair
            assign mirror = x_q[NUM_TAPS-1-k];
        end else begin : g_centre
            assign mirror = '0;
        end

        srrc_preadd_mult #(
            .COEF(COEF_W'(srrc_coef(k)))
        ) u_pm (
            .clk       (clk),
            .reset_n   (reset_n),
            .sam_clk_en(sam_clk_en),
            .tap_a     (x_q[k]),
            .tap_b     (mirror),
            .prod      (prod[k])
        );
    end

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k <= TAP_CENTRE; k++) begin
            acc_sum = acc_sum + ACC_W'(prod[k]);
        end
        acc_d = sam_clk_en ? acc_sum : acc_q;
    end

    // Guard bits above the output MSB must all agree with it, otherwise clamp to full scale.
    always_comb begin
        acc_rnd = acc_q + ROUND_ADD;
        ovf     = !((&acc_rnd[ACC_W-1:OUT_MSB]) || !(|acc_rnd[ACC_W-1:OUT_MSB]));
        if (ovf) begin
            sat_val = acc_rnd[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_val = acc_rnd[OUT_MSB:FRAC_W];
        end
        out_d = sam_clk_en ? sat_val : out_q;
    end

    assign unused_frac = ^acc_rnd[FRAC_W-1:0];

    always_comb begin
        cnt_d = cnt_q;
        if (sam_clk_en && (cnt_q != CNT_W'(FILL_DONE))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_q[k] <= '0;
            end
            acc_q <= '0;
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            acc_q <= acc_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_out   = out_q;
    assign data_valid = (cnt_q == CNT_W'(FILL_DONE));

endmodule

// File: tb/tb_srrc_tx_filter.sv
// Scoreboard bench for srrc_tx_filter: a direct-convolution model queues the expected output of
// every enable, a monitor pops/compares on enables and checks the hold value in between.
module tb_srrc_tx_filter;

    import mod_tx_pkg::*;

    typedef struct {
        logic [17:0] data;
        logic        valid;
    } exp_t;

    logic               clk;
    logic               reset_n;
    logic               sam_clk_en;
    logic signed [17:0] data_in;
    logic signed [17:0] data_out;
    logic               data_valid;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        exp_q[$];
    longint      hist [0:20];
    int          model_cnt;
    logic [17:0] last_out   = '0;
    logic        last_valid = 1'b0;

`ifdef SRRC_ROUND_EN
    localparam logic [17:0] IMP_FIRST = 18'd1391;
`else
    localparam logic [17:0] IMP_FIRST = 18'd1390;
`endif
    localparam logic [17:0] IMP_CENTRE = 18'h06D65;
    localparam logic [17:0] DC_LEVEL   = 18'h1857B;

    srrc_tx_filter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sam_clk_en(sam_clk_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint tap_coef(input int k);
        int m;
        m = (k > CENTRE) ? (NUM_TAPS - 1 - k) : k;
        return longint'(srrc_coef(m));
    endfunction

    function automatic logic [17:0] model_out(input longint acc);
        longint q;
`ifdef SRRC_ROUND_EN
        q = (acc + 64'sd65536) >>> 17;
`else
        q = acc >>> 17;
`endif
        if (q > 131071) return 18'h1FFFF;
        if (q < -131072) return 18'h20000;
        return q[17:0];
    endfunction

    task automatic checkOutput(input string name, input logic [17:0] actual, input logic [17:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 18'h%05h, expected 18'h%05h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int j = 0; j <= 20; j++) hist[j] = 0;
        model_cnt = 0;
        exp_q.delete();
    endtask

    task automatic applyStimulus(input logic [17:0] v);
        longint acc;
        @(negedge clk);
        sam_clk_en = 1'b1;
        data_in    = v;
        for (int j = 20; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = longint'($signed(v));
        acc = 0;
        for (int k = 0; k < NUM_TAPS; k++) acc += tap_coef(k) * hist[4+k];
        if (model_cnt < FILL_MAX) model_cnt++;
        exp_q.push_back('{data: model_out(acc), valid: (model_cnt == FILL_MAX)});
        @(posedge clk);
        #2;
        sam_clk_en = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        sam_clk_en = 1'b0;
        reset_n    = 1'b0;
        clearModel();
        #1;
        checkOutput("rst_data", data_out, 18'h0);
        checkOutput("rst_valid", {17'b0, data_valid}, 18'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: pop on every enable, otherwise the output must hold its last value.
    always @(posedge clk) begin
        exp_t e;
        if (!reset_n) begin
            last_out   = '0;
            last_valid = 1'b0;
        end else if (sam_clk_en) begin
            #1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL sb_empty: got output 18'h%05h, expected a queued entry", data_out);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_data", data_out, e.data);
                checkOutput("sb_valid", {17'b0, data_valid}, {17'b0, e.valid});
                last_out   = e.data;
                last_valid = e.valid;
            end
        end else begin
            #1;
            checkOutput("hold_data", data_out, last_out);
            checkOutput("hold_valid", {17'b0, data_valid}, {17'b0, last_valid});
        end
    end

    initial begin
        logic [17:0] gap_vec [12] = '{18'h10000, 18'h08000, 18'h3C000, 18'h00000,
                                      18'h1FFFF, 18'h20000, 18'h04000, 18'h30000,
                                      18'h00001, 18'h3FFFF, 18'h12345, 18'h2ABCD};
        reset_n    = 1'b1;
        sam_clk_en = 1'b0;
        data_in    = '0;
        clearModel();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("init_data", data_out, 18'h0);
        checkOutput("init_valid", {17'b0, data_valid}, 18'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idleCycles(3);

        // Cold-start impulse of 0.5
        applyStimulus(18'h10000);
        repeat (4) applyStimulus(18'h0);
        checkOutput("imp_first", data_out, IMP_FIRST);
        repeat (8) applyStimulus(18'h0);
        checkOutput("imp_centre", data_out, IMP_CENTRE);
        repeat (12) applyStimulus(18'h0);
        checkOutput("imp_tail_zero", data_out, 18'h0);

        // Reset at tick 10 of an impulse run, then a fresh impulse
        applyStimulus(18'h10000);
        repeat (9) applyStimulus(18'h0);
        doReset();
        idleCycles(2);
        applyStimulus(18'h10000);
        repeat (4) applyStimulus(18'h0);
        checkOutput("rst_imp_first", data_out, IMP_FIRST);
        repeat (8) applyStimulus(18'h0);
        checkOutput("rst_imp_centre", data_out, IMP_CENTRE);
        repeat (12) applyStimulus(18'h0);

        // DC 0.5 held, including the data_valid edge on the 20th enable
        doReset();
        repeat (19) applyStimulus(18'h10000);
        checkOutput("valid_19", {17'b0, data_valid}, 18'h0);
        applyStimulus(18'h10000);
        checkOutput("valid_20", {17'b0, data_valid}, 18'h1);
        repeat (4) applyStimulus(18'h10000);
        checkOutput("dc_level", data_out, DC_LEVEL);

        // Positive full scale held saturates
        repeat (24) applyStimulus(18'h1FFFF);
        checkOutput("sat_pos", data_out, 18'h1FFFF);

        // Sign pattern matched to the taps drives a negative peak into saturation
        for (int i = 0; i < NUM_TAPS; i++) begin
            applyStimulus((tap_coef(NUM_TAPS - 1 - i) > 0) ? 18'h20000 : 18'h1FFFF);
        end
        repeat (4) applyStimulus(18'h0);
        checkOutput("sat_neg", data_out, 18'h20000);
        repeat (20) applyStimulus(18'h0);

        // Random gaps between enables
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(gap_vec[i]);
            idleCycles(int'($urandom_range(7, 1)));
        end
        for (int i = 0; i < 21; i++) begin
            applyStimulus(18'h0);
            idleCycles(int'($urandom_range(7, 1)));
        end

        idleCycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
